rf_param: RTL and testbench

//  Parametrised, memory-mapped register file; successor to the fixed 64-bit rf.

---
 rtl/rf_param_if.sv | 44 ++++
 rtl/rf_param.sv | 107 ++++++++++
 tb/tb_rf_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_param_if
//  Description : Request/response bundle between a bus master and the rf_param
//                register file. The parity ports exist only when
//                RF_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_param_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                we;
    logic                re;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                err;
`ifdef RF_PARITY_EN
    logic                perr;
    logic                par_inj;

    modport master (
        output addr, wdata, wstrb, we, re, par_inj,
        input  rdata, rvalid, err, perr
    );
    modport slave (
        input  addr, wdata, wstrb, we, re, par_inj,
        output rdata, rvalid, err, perr
    );
`else
    modport master (
        output addr, wdata, wstrb, we, re,
        input  rdata, rvalid, err
    );
    modport slave (
        input  addr, wdata, wstrb, we, re,
        output rdata, rvalid, err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rf_param.sv
`default_nettype none
// ============================================================================
//  Module      : rf_param
//  Description : Parametrised memory-mapped register file. Decodes DEPTH words
//                starting at BASE_ADDR, byte-strobed writes, one-cycle
//                registered reads with a valid pulse, and an out-of-window
//                error pulse. Optional per-entry even parity with error
//                injection is enabled by defining RF_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_param #(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 64,
    parameter int              DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h0100)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    rf_param_if.slave   bus
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Window bounds held one bit wider than the address so the upper bound
    // never wraps when the window touches the top of the address space.
    localparam logic [ADDR_W:0] c_lo = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] c_hi = c_lo + (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;

    logic [ADDR_W:0]   w_addr_ext;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_merged;

    // Window decode and word index.
    always_comb begin
        w_addr_ext = {1'b0, bus.addr};
        w_hit      = (w_addr_ext >= c_lo) && (w_addr_ext < c_hi);
        w_idx      = IDX_W'(w_addr_ext - c_lo);
        w_cur      = r_mem[w_idx];
    end

    // Byte-wise merge of incoming write data over the current entry.
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign w_merged[8*gi +: 8] = bus.wstrb[gi] ? bus.wdata[8*gi +: 8]
                                                   : w_cur[8*gi +: 8];
    end

`ifdef RF_PARITY_EN
    logic [DEPTH-1:0] r_par;
    logic             r_perr;

    // Parity store: even parity of the merged word, optionally inverted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par  <= '0;
            r_perr <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            if (bus.we) begin
                if (w_hit) r_par[w_idx] <= (^w_merged) ^ bus.par_inj;
            end else if (bus.re && w_hit) begin
                r_perr <= (^w_cur) != r_par[w_idx];
            end
        end
    end

    assign bus.perr = r_perr;
`endif

    // Storage and response path; a write in the same cycle as a read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (bus.we) begin
                if (w_hit) r_mem[w_idx] <= w_merged;
                else       r_err        <= 1'b1;
            end else if (bus.re) begin
                r_rvalid <= 1'b1;
                if (w_hit) begin
                    r_rdata <= w_cur;
                end else begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_param
//  Description : Self-checking bench for rf_param. Stimulus updates a simple
//                array model and queues expected responses; a monitor pops
//                and compares whenever the DUT pulses rvalid or err.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_param;

    localparam int BASE  = 256;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic        rv;
        logic        err;
        logic [63:0] data;
        logic        perr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int   checks = 0;
    int   errors = 0;

    exp_t        q[$];
    exp_t        mon_e;
    logic [63:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    logic [63:0] m_last;

    rf_param_if #(.ADDR_W(16), .DATA_W(64)) bus ();

    rf_param #(
        .ADDR_W    (16),
        .DATA_W    (64),
        .DEPTH     (64),
        .BASE_ADDR (16'h0100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (bus.rvalid === 1'b1 || bus.err === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rvalid=%b err=%b expected no pulse (t=%0t)",
                         bus.rvalid, bus.err, $time);
            end else begin
                mon_e = q.pop_front();
                chk("rvalid", 64'(bus.rvalid), 64'(mon_e.rv));
                chk("err",    64'(bus.err),    64'(mon_e.err));
                if (mon_e.rv) chk("rdata", bus.rdata, mon_e.data);
`ifdef RF_PARITY_EN
                chk("perr", 64'(bus.perr), 64'(mon_e.perr));
`endif
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 1'b0;
        end
        m_last = '0;
    endtask

    task automatic drive(input logic w, input logic r, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] s, input logic inj);
        bus.we    = w;
        bus.re    = r;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = s;
`ifdef RF_PARITY_EN
        bus.par_inj = inj;
`endif
    endtask

    // One bus cycle: update the model, queue the expected pulse, clock it in.
    task automatic access(input logic w, input logic r, input logic [15:0] a,
                          input logic [63:0] d, input logic [7:0] s, input logic inj);
        int   ai;
        int   idx;
        bit   hit;
        exp_t e;
        ai  = int'(a);
        hit = (ai >= BASE) && (ai < BASE + DEPTH);
        idx = hit ? ai - BASE : 0;
        drive(w, r, a, d, s, inj);
        if (w) begin
            if (hit) begin
                for (int b = 0; b < 8; b++)
                    if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
                m_bad[idx] = inj;
            end else begin
                e = '{rv: 1'b0, err: 1'b1, data: 64'd0, perr: 1'b0};
                q.push_back(e);
            end
        end else if (r) begin
            e.rv   = 1'b1;
            e.err  = !hit;
            e.data = hit ? m_mem[idx] : 64'd0;
            e.perr = hit ? m_bad[idx] : 1'b0;
            m_last = e.data;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s, input logic inj);
        access(1'b1, 1'b0, a, d, s, inj);
    endtask

    task automatic rd(input logic [15:0] a);
        access(1'b0, 1'b1, a, 64'd0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b0, 1'b0, 16'h0000, 64'd0, 8'h00, 1'b0);
    endtask

    // Reset for n cycles, optionally with a write pending to 0x0101.
    task automatic apply_reset(input int n, input bit with_write);
        reset = 1'b1;
        if (with_write) drive(1'b1, 1'b0, 16'h0101, 64'hDEAD_BEEF_0000_5555, 8'hFF, 1'b0);
        else            drive(1'b0, 1'b0, 16'h0000, 64'd0, 8'h00, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 64'd0, 8'h00, 1'b0);
        model_clear();
        chk("reset_rvalid", 64'(bus.rvalid), 64'd0);
        chk("reset_err",    64'(bus.err),    64'd0);
        chk("reset_rdata",  bus.rdata,       64'd0);
`ifdef RF_PARITY_EN
        chk("reset_perr",   64'(bus.perr),   64'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          sel;
        model_clear();
        drive(1'b0, 1'b0, 16'h0000, 64'd0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        apply_reset(2, 1'b0);

        // Whole window reads zero after reset, back to back.
        for (int i = 0; i < DEPTH; i++) rd(16'(BASE + i));

        // Simple write/read, then out-of-window write and read.
        wr(16'h0120, 64'h1111, 8'hFF, 1'b0);
        rd(16'h0120);
        wr(16'h0001, 64'h2222, 8'hFF, 1'b0);
        rd(16'h0001);

        // Partial strobes, including an all-zero strobe no-op.
        wr(16'h0105, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        wr(16'h0105, 64'd0, 8'h0F, 1'b0);
        rd(16'h0105);
        wr(16'h0105, 64'h1234_5678_9ABC_DEF0, 8'h00, 1'b0);
        rd(16'h0105);

        // Write wins over a simultaneous read.
        access(1'b1, 1'b1, 16'h0101, 64'h3333, 8'hFF, 1'b0);
        rd(16'h0101);
        idle(2);
        chk("rdata_hold", bus.rdata, m_last);

        // Reset with a write pending: entry must come back zero.
        apply_reset(1, 1'b1);
        rd(16'h0101);

        // Window edges and the top of the address space.
        wr(16'h0100, 64'hA5A5_0000_0000_0001, 8'hFF, 1'b0);
        wr(16'h013F, 64'h5A5A_0000_0000_0002, 8'hFF, 1'b0);
        wr(16'h0140, 64'hBAD0, 8'hFF, 1'b0);
        wr(16'hFFFF, 64'hBAD1, 8'hFF, 1'b0);
        rd(16'h00FF);
        rd(16'h0100);
        rd(16'h013F);
        rd(16'h0140);
        rd(16'hFFFF);
        rd(16'h0000);

`ifdef RF_PARITY_EN
        // Parity injection and recovery.
        wr(16'h0110, 64'h7, 8'hFF, 1'b1);
        rd(16'h0110);
        wr(16'h0110, 64'h7, 8'hFF, 1'b0);
        rd(16'h0110);
`endif

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 16'(BASE + int'($urandom_range(0, DEPTH - 1)));
            else if (sel == 7) a = ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0140;
            else if (sel == 8) a = 16'($urandom);
            else               a = 16'hFFFF;
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        idle(3);
        chk("rdata_hold_end", bus.rdata, m_last);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
